// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Purpose  : Shared AES-128 types and constants: round count, key width,
//            word/block typedefs, key-expander state encoding and the round
//            constant (Rcon) lookup.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int AES_NR      = 10;
    localparam int AES_NK_BITS = 128;

    typedef logic [31:0]            word_t;
    typedef logic [AES_NK_BITS-1:0] block_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Rcon[1..10]; index 0 and 11..15 are never used by a live round.
    function automatic logic [7:0] aesRcon(input logic [3:0] rnd);
        logic [7:0] rc;
        case (rnd)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// Module   : aes_sbox
// Purpose  : Combinational AES forward S-box (one byte). Used four times by
//            the key expander for SubWord and by the cipher SubBytes stage.
// Ports    : i_data [7:0] - input byte
//            o_data [7:0] - substituted byte
// Revision : 1.0 - initial release
// ============================================================================
module aes_sbox (
    input  logic [7:0] i_data,
    output logic [7:0] o_data
);

    // Entry 0 sits in the most significant byte, so entry x starts at bit
    // (255 - x) * 8, i.e. {~x, 3'b000}.
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] w_bitIdx;

    assign w_bitIdx = {~i_data, 3'b000};
    assign o_data   = c_SBOX[w_bitIdx +: 8];

endmodule
`default_nettype wire

// File: rtl/aes_key_expander.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_expander
// Purpose  : AES-128 key expansion. One round key per clock, eleven round
//            keys held in registers and read through an indexed port.
//            ReadyKey is intended to gate the cipher round scheduler reset.
// Ports    : Clk             - clock, rising edge
//            Rst             - synchronous active-high reset
//            KeyLoad         - one-cycle request to expand KeyIn
//            KeyIn   [127:0] - cipher key, byte 0 in [127:120]
//            RkIdx   [3:0]   - read port index (11..15 read as zero)
//            RoundKey[127:0] - round key at RkIdx (combinational read)
//            ReadyKey        - all eleven round keys valid
//            Busy            - expansion in progress
// Options  : KEY_RESTART_EN  - when defined, KeyLoad during expansion
//                              restarts from the new key; otherwise it is
//                              ignored and the current expansion completes.
// Revision : 1.0 - initial release
// ============================================================================
module aes_key_expander
    import aes_pkg::*;
(
    input  logic         Clk,
    input  logic         Rst,
    input  logic         KeyLoad,
    input  logic [127:0] KeyIn,
    input  logic [3:0]   RkIdx,
    output logic [127:0] RoundKey,
    output logic         ReadyKey,
    output logic         Busy
);

    state_t     r_state;
    logic [3:0] r_rnd;
    block_t     r_rk [0:AES_NR];
    logic       r_readyKey;
    logic       r_busy;

    block_t     w_prev;
    word_t      w_w0, w_w1, w_w2, w_w3;
    word_t      w_rot, w_sub, w_t;
    word_t      w_n0, w_n1, w_n2, w_n3;
    logic       w_accept;

`ifdef KEY_RESTART_EN
    assign w_accept = KeyLoad;
`else
    assign w_accept = KeyLoad && (r_state != EXPAND);
`endif

    // rk[Rnd-1]; outside EXPAND the value is unused.
    always_comb begin
        w_prev = '0;
        for (int i = 0; i < AES_NR; i++) begin
            if (r_rnd == 4'(i + 1)) begin
                w_prev = r_rk[i];
            end
        end
    end

    assign {w_w0, w_w1, w_w2, w_w3} = w_prev;
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    generate
        for (genvar j = 0; j < 4; j++) begin : g_subWord
            aes_sbox u_sbox (
                .i_data (w_rot[8*j +: 8]),
                .o_data (w_sub[8*j +: 8])
            );
        end
    endgenerate

    assign w_t  = w_sub ^ {aesRcon(r_rnd), 24'h0};
    assign w_n0 = w_w0 ^ w_t;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state    <= IDLE;
            r_rnd      <= 4'd0;
            r_readyKey <= 1'b0;
            r_busy     <= 1'b0;
            for (int i = 0; i <= AES_NR; i++) begin
                r_rk[i] <= '0;
            end
        end else if (w_accept) begin
            // Clearing rk1..rk10 keeps stale keys of a previous expansion
            // from being read back during the new one.
            r_rk[0] <= KeyIn;
            for (int i = 1; i <= AES_NR; i++) begin
                r_rk[i] <= '0;
            end
            r_rnd      <= 4'd1;
            r_state    <= EXPAND;
            r_readyKey <= 1'b0;
            r_busy     <= 1'b1;
        end else begin
            case (r_state)
                EXPAND: begin
                    for (int i = 1; i <= AES_NR; i++) begin
                        if (r_rnd == 4'(i)) begin
                            r_rk[i] <= {w_n0, w_n1, w_n2, w_n3};
                        end
                    end
                    if (r_rnd == 4'(AES_NR)) begin
                        r_state    <= DONE;
                        r_readyKey <= 1'b1;
                        r_busy     <= 1'b0;
                    end else begin
                        r_rnd <= r_rnd + 4'd1;
                    end
                end
                default: begin
                    // IDLE and DONE hold until a load or reset.
                end
            endcase
        end
    end

    always_comb begin
        RoundKey = '0;
        for (int i = 0; i <= AES_NR; i++) begin
            if (RkIdx == 4'(i)) begin
                RoundKey = r_rk[i];
            end
        end
    end

    assign ReadyKey = r_readyKey;
    assign Busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expander.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_key_expander
// Purpose  : Self-checking bench for aes_key_expander. Expected round-key
//            sets are pushed into a scoreboard at every accepted load; a
//            monitor pops one whenever ReadyKey rises and compares timing
//            and all eleven keys. The reference S-box is derived from
//            GF(2^8) inversion and the affine map.
// Options  : KEY_RESTART_EN - must match the RTL build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_key_expander;

    localparam logic [127:0] c_KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_A1_RK1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] c_A1_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] c_ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    typedef struct packed {
        logic [10:0][127:0] rks;
        int                 loadEdge;
    } exp_t;

    logic         Clk;
    logic         Rst;
    logic         KeyLoad;
    logic [127:0] KeyIn;
    logic [3:0]   RkIdx;
    logic [127:0] RoundKey;
    logic         ReadyKey;
    logic         Busy;

    logic [3:0]   stimIdx;
    logic [3:0]   monIdx;
    logic         monSel;

    int           cyc;
    int           nCmp;
    int           nErr;
    int           lastN;
    exp_t         sb [$];
    logic [7:0]   sboxTab [256];

    assign RkIdx = monSel ? monIdx : stimIdx;

    aes_key_expander dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .KeyLoad  (KeyLoad),
        .KeyIn    (KeyIn),
        .RkIdx    (RkIdx),
        .RoundKey (RoundKey),
        .ReadyKey (ReadyKey),
        .Busy     (Busy)
    );

    initial Clk = 1'b0;
    always #20 Clk = ~Clk;

    initial cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] refSbox(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {sboxTab[w[31:24]], sboxTab[w[23:16]], sboxTab[w[15:8]], sboxTab[w[7:0]]};
    endfunction

    function automatic logic [10:0][127:0] expandKey(input logic [127:0] key);
        logic [31:0]        w [44];
        logic [31:0]        t;
        logic [7:0]         rc = 8'h01;
        logic [10:0][127:0] rk;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = subWord({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic readKey(input logic [3:0] idx, output logic [127:0] val);
        stimIdx = idx;
        #1;
        val = RoundKey;
    endtask

    // Called at a negedge; drives KeyLoad for the next rising edge only.
    task automatic doLoad(input logic [127:0] key);
        int   e;
        logic expanding;
        logic acc;
        KeyLoad   = 1'b1;
        KeyIn     = key;
        e         = cyc + 1;
        expanding = (e >= lastN + 1) && (e <= lastN + 10);
`ifdef KEY_RESTART_EN
        acc = 1'b1;
        if (expanding) void'(sb.pop_back());
`else
        acc = !expanding;
`endif
        if (acc) begin
            sb.push_back('{rks: expandKey(key), loadEdge: e});
            lastN = e;
        end
        @(negedge Clk);
        KeyLoad = 1'b0;
        if (acc) begin
            chk("busy_after_load", {127'd0, Busy}, 128'd1);
            chk("ready_drop_at_load", {127'd0, ReadyKey}, 128'd0);
        end
    endtask

    task automatic waitReady(input string name, output int edgeSeen);
        logic found = 1'b0;
        edgeSeen = -1;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge Clk);
            if (ReadyKey) begin
                found    = 1'b1;
                edgeSeen = cyc;
            end
        end
        if (!found) begin
            nCmp++;
            nErr++;
            $display("FAIL %s: ReadyKey timeout, got 0 expected 1", name);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        logic prevRdy = 1'b0;
        exp_t e;
        monSel = 1'b0;
        monIdx = 4'd0;
        forever begin
            @(negedge Clk);
            if (ReadyKey && !prevRdy) begin
                if (sb.size() == 0) begin
                    nCmp++;
                    nErr++;
                    $display("FAIL unexpected_ready: got ReadyKey=1 at edge %0d expected no completion", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("ready_latency", 128'(cyc), 128'(e.loadEdge + 10));
                    chk("busy_at_ready", {127'd0, Busy}, 128'd0);
                    monSel = 1'b1;
                    for (int i = 0; i < 11; i++) begin
                        monIdx = 4'(i);
                        #1;
                        chk($sformatf("rk%0d", i), RoundKey, e.rks[i]);
                    end
                    monIdx = 4'd12;
                    #1;
                    chk("rk_idx12_zero", RoundKey, 128'd0);
                    monSel = 1'b0;
                end
            end
            prevRdy = ReadyKey;
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        logic [127:0] v;
        int           n1;
        int           rEdge;
        nCmp    = 0;
        nErr    = 0;
        lastN   = -100;
        Rst     = 1'b1;
        KeyLoad = 1'b0;
        KeyIn   = '0;
        stimIdx = 4'd0;
        for (int i = 0; i < 256; i++) sboxTab[i] = refSbox(8'(i));

        // Reset
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        chk("reset_ready", {127'd0, ReadyKey}, 128'd0);
        chk("reset_busy", {127'd0, Busy}, 128'd0);
        readKey(4'd0, v);  chk("reset_rk0", v, 128'd0);
        readKey(4'd10, v); chk("reset_rk10", v, 128'd0);

        // FIPS-197 A.1
        @(negedge Clk);
        n1 = cyc + 1;
        doLoad(c_KEY_A1);
        waitReady("a1", rEdge);
        chk("a1_latency", 128'(rEdge), 128'(n1 + 10));
        @(negedge Clk);
        readKey(4'd1, v);  chk("a1_rk1", v, c_A1_RK1);
        readKey(4'd10, v); chk("a1_rk10", v, c_A1_RK10);
        readKey(4'd12, v); chk("a1_idx12", v, 128'd0);

        // Reload from DONE with all-zero key
        n1 = cyc + 1;
        doLoad(128'd0);
        waitReady("zero", rEdge);
        chk("zero_latency", 128'(rEdge), 128'(n1 + 10));
        @(negedge Clk);
        readKey(4'd10, v); chk("zero_rk10", v, c_ZERO_RK10);

        // Mid-expansion load at Rnd = 4
        n1 = cyc + 1;
        doLoad(c_KEY_A1);
        repeat (3) @(negedge Clk);
        doLoad(128'd0);
        waitReady("mid", rEdge);
`ifdef KEY_RESTART_EN
        chk("mid_latency", 128'(rEdge), 128'(n1 + 14));
        @(negedge Clk);
        readKey(4'd10, v); chk("mid_rk10", v, c_ZERO_RK10);
`else
        chk("mid_latency", 128'(rEdge), 128'(n1 + 10));
        @(negedge Clk);
        readKey(4'd10, v); chk("mid_rk10", v, c_A1_RK10);
`endif
        repeat (12) @(negedge Clk);

        // Reset at Rnd = 6
        n1 = cyc + 1;
        doLoad({$urandom, $urandom, $urandom, $urandom});
        while (cyc < n1 + 5) @(negedge Clk);
        Rst = 1'b1;
        void'(sb.pop_back());
        lastN = -100;
        @(negedge Clk);
        chk("midrst_ready", {127'd0, ReadyKey}, 128'd0);
        chk("midrst_busy", {127'd0, Busy}, 128'd0);
        for (int i = 0; i < 16; i++) begin
            readKey(4'(i), v);
            chk($sformatf("midrst_rk%0d", i), v, 128'd0);
        end
        Rst = 1'b0;
        @(negedge Clk);

        // Load in the cycle ReadyKey rises
        n1 = cyc + 1;
        doLoad({$urandom, $urandom, $urandom, $urandom});
        waitReady("b2b_first", rEdge);
        chk("b2b_first_latency", 128'(rEdge), 128'(n1 + 10));
        n1 = cyc + 1;
        doLoad({$urandom, $urandom, $urandom, $urandom});
        waitReady("b2b_second", rEdge);
        chk("b2b_second_latency", 128'(rEdge), 128'(n1 + 10));
        @(negedge Clk);

        // Randomized loads with random gaps (including mid-expansion)
        for (int k = 0; k < 20; k++) begin
            doLoad({$urandom, $urandom, $urandom, $urandom});
            repeat ($urandom_range(0, 13)) @(negedge Clk);
        end
        repeat (15) @(negedge Clk);
        chk("scoreboard_drained", 128'(sb.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nCmp, nErr);
        $finish;
    end

endmodule
`default_nettype wire
